// File: rtl/ysyx_sram_rsp.sv
// rtl/ysyx_sram_rsp.sv - SRAM-backed read/write responder with a fixed response latency
// One request in flight at a time; a read offered together with a write is served first.
module ysyx_sram_rsp #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                DEPTH_LOG2 = 10,
   parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
   parameter int                LATENCY    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              rresp,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        wstrb,
   input  logic              wvalid,
   output logic              bvalid,
   output logic              bresp
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] WR_WAIT = 2'd2;

   localparam int              DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
   localparam logic [ADDR_W:0] BASE_X   = {1'b0, BASE};
   localparam logic [ADDR_W:0] LIMIT_X  = BASE_X + (ADDR_W + 1)'(4 * DEPTH);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [DATA_W-1:0] rdata_q;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic [ADDR_W-1:0]     offset;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  in_range;
   logic                  done;
   logic                  rd_fire;
   logic                  wr_fire;
   logic [DATA_W-1:0]     rd_word;

   // Range and index are always derived from the latched address, never the live bus.
   assign offset   = addr_q - BASE;
   assign idx      = DEPTH_LOG2'(offset >> 2);
   assign in_range = ({1'b0, addr_q} >= BASE_X) && ({1'b0, addr_q} < LIMIT_X);
   assign done     = (cnt_q == 4'd0);
   assign rd_fire  = (state_q == RD_WAIT) && done;
   assign wr_fire  = (state_q == WR_WAIT) && done;
   assign rd_word  = in_range ? mem[idx] : '0;

   assign rvalid = rd_fire;
   assign rresp  = rd_fire & ~in_range;
   assign rdata  = rd_fire ? rd_word : rdata_q;
   assign bvalid = wr_fire;
   assign bresp  = wr_fire & ~in_range;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      case (state_q)
         IDLE: begin
            if (arvalid) begin
               addr_d  = araddr;
               cnt_d   = CNT_INIT;
               state_d = RD_WAIT;
            end else if (awvalid && wvalid) begin
               addr_d  = awaddr;
               wdata_d = wdata;
               wstrb_d = wstrb;
               cnt_d   = CNT_INIT;
               state_d = WR_WAIT;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (done) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= 4'd0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         if (rd_fire) begin
            rdata_q <= rd_word;
         end
      end
   end

   // Memory has no reset; a reset on the bvalid edge suppresses the pending write.
   always_ff @(posedge clk) begin
      if (!rst && wr_fire && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
               mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule
